vr_vc_converter: RTL and testbench

VR_VC_CONVERTER -- requirements
Module: vr_vc_converter

---
 rtl/vr_vc_converter_if.sv | 27 ++
 rtl/vr_vc_converter.sv | 52 +++++
 tb/tb_vr_vc_converter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vr_vc_converter_if.sv
// Handshake bundle for the valid/ready to valid/credit converter.
// slave is the converter's view, master is the driver/receiver side.
interface vr_vc_converter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
);
    localparam int CNT_W = $clog2(CREDIT_NUM + 1);

    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_credit_i;
    logic [CNT_W-1:0]      credit_cnt_o;
    logic                  credit_ovf_o;

    modport slave (
        input  s_data_i, s_valid_i, m_credit_i,
        output s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_ovf_o
    );

    modport master (
        output s_data_i, s_valid_i, m_credit_i,
        input  s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_ovf_o
    );
endinterface

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter: 1-cycle registered output, no data buffering;
// backpressure only via s_ready_o, which is high whenever a downstream credit is held.
module vr_vc_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
) (
    input logic             clk,
    input logic             rst,
    vr_vc_converter_if.slave bus
);
    localparam int              CNT_W   = $clog2(CREDIT_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_NUM);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]      cnt;
    logic                  ovf;
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
    logic                  ready;
    logic                  accept;

    // Ready comes from the count register alone so no input reaches it combinationally.
    assign ready  = (cnt != '0);
    assign accept = bus.s_valid_i && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
            vld <= 1'b0;
            dat <= '0;
        end else begin
            case ({accept, bus.m_credit_i})
                2'b10:   cnt <= cnt - CNT_ONE;
                2'b01: begin
                    // A credit beyond the receiver's depth is a protocol error; saturate and flag it.
                    if (cnt == CNT_MAX) ovf <= 1'b1;
                    else                cnt <= cnt + CNT_ONE;
                end
                default: cnt <= cnt;
            endcase
            vld <= accept;
            if (accept) dat <= bus.s_data_i;
        end
    end

    assign bus.s_ready_o    = ready;
    assign bus.m_valid_o    = vld;
    assign bus.m_data_o     = dat;
    assign bus.credit_cnt_o = cnt;
    assign bus.credit_ovf_o = ovf;
endmodule

// File: tb/tb_vr_vc_converter.sv
// Bench for vr_vc_converter: directed scenarios plus random end-to-end traffic into a credit receiver.
module tb_vr_vc_converter;
    localparam int DW = 8;
    localparam int CN = 2;

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int            model_cnt = 0;
    bit            model_ovf = 1'b0;
    exp_t          exp_q[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] rx_q[$];
    int            rcvd = 0;

    vr_vc_converter_if #(.DATA_WIDTH(DW), .CREDIT_NUM(CN)) bus ();

    vr_vc_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: check state against the model, then drive the next inputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic c,
                        input bit use_rx, output bit acc);
        logic          crd;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        @(negedge clk);
        chk("credit_cnt", int'(bus.credit_cnt_o), model_cnt);
        chk("s_ready", int'(bus.s_ready_o), int'(model_cnt != 0));
        chk("credit_ovf", int'(bus.credit_ovf_o), int'(model_ovf));
        crd = c;
        if (use_rx) begin
            if (bus.m_valid_o) begin
                rx_q.push_back(bus.m_data_o);
                chk("rx_fill_ok", int'(rx_q.size() <= CN), 1);
            end
            crd = 1'b0;
            if (rx_q.size() > 0 && $urandom_range(1, 0) == 1) begin
                crd = 1'b1;
                got = rx_q.pop_front();
                rcvd++;
                if (sent_q.size() == 0) begin
                    chk("e2e_extra_beat", int'(got), -1);
                end else begin
                    want = sent_q.pop_front();
                    chk("e2e_data", int'(got), int'(want));
                end
            end
        end
        bus.s_valid_i  = v;
        bus.s_data_i   = d;
        bus.m_credit_i = crd;
        acc = v && (model_cnt > 0);
        if (acc) begin
            exp_q.push_back('{dat: d, cyc: cyc});
            if (use_rx) sent_q.push_back(d);
        end
        if (acc && !crd) model_cnt--;
        else if (!acc && crd) begin
            if (model_cnt == CN) model_ovf = 1'b1;
            else                 model_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid_i  = 1'b1;
        bus.m_credit_i = 1'b1;
        bus.s_data_i   = 8'h5A;
        exp_q.delete();
        sent_q.delete();
        rx_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cnt", int'(bus.credit_cnt_o), 0);
        chk("rst_ready", int'(bus.s_ready_o), 0);
        chk("rst_mvalid", int'(bus.m_valid_o), 0);
        chk("rst_mdata", int'(bus.m_data_o), 0);
        chk("rst_ovf", int'(bus.credit_ovf_o), 0);
        bus.s_valid_i  = 1'b0;
        bus.m_credit_i = 1'b0;
        bus.s_data_i   = '0;
        rst = 1'b0;
    endtask

    // Monitor: every beat the DUT emits must match the oldest expected beat, one cycle after acceptance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.m_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_mvalid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", int'(bus.m_data_o), int'(e.dat));
                        chk("m_latency", cyc - e.cyc, 1);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_mvalid", 0, 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        bit            have;
        logic [DW-1:0] cur;
        int            accepted;
        int            guard;

        bus.s_valid_i  = 1'b0;
        bus.s_data_i   = '0;
        bus.m_credit_i = 1'b0;
        do_reset();

        // Initial credit grant: count 0,1,2 with ready rising after the first pulse.
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // Drain two credits with A1, A2; A3 must wait for a new credit.
        step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA2, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA3, 1'b0, 1'b0, acc);
        chk("drain_a3_held", int'(acc), 0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA3, 1'b1, 1'b0, acc);
        step(1'b1, 8'hA3, 1'b0, 1'b0, acc);
        chk("drain_a3_accepted", int'(acc), 1);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // Accept and credit in the same cycle at count 1.
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b1, 8'hB5, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // Credit at full count sets the sticky overflow flag.
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, acc);

        // Asynchronous reset while a beat is on the output.
        step(1'b1, 8'hC7, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        chk("mid_mvalid_before", int'(bus.m_valid_o), 1);
        rst = 1'b1;
        #1;
        chk("mid_mvalid_async", int'(bus.m_valid_o), 0);
        chk("mid_cnt_async", int'(bus.credit_cnt_o), 0);
        chk("mid_ready_async", int'(bus.s_ready_o), 0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // Random end-to-end traffic into a receiver with CN slots and random drain.
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        have = 1'b0;
        cur = '0;
        accepted = 0;
        guard = 0;
        rcvd = 0;
        while (accepted < 1000 && guard < 20000) begin
            if (!have && $urandom_range(3, 0) != 0) begin
                have = 1'b1;
                cur = DW'($urandom);
            end
            step(have, have ? cur : '0, 1'b0, 1'b1, acc);
            if (acc) begin
                have = 1'b0;
                accepted++;
            end
            guard++;
        end
        chk("e2e_sent", accepted, 1000);
        guard = 0;
        while ((sent_q.size() > 0 || rx_q.size() > 0 || exp_q.size() > 0) && guard < 500) begin
            step(1'b0, '0, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("e2e_rcvd", rcvd, 1000);
        chk("e2e_pending", exp_q.size() + sent_q.size(), 0);
        chk("e2e_no_ovf", int'(bus.credit_ovf_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
